// File: rtl/gpu_cmd_parser_if.sv
// Byte-stream command channel into the GPU command parser.
// The master drives bytes with a valid flag, and the parser answers with ready.
interface gpu_cmd_parser_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/gpu_cmd_parser.sv
// Parses 7-byte rectangle-fill packets, range-checks them and issues a single fill request.
// It then stays busy for exactly as long as the fill engine needs to finish.
module gpu_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int X_MAX          = 319,
    parameter int Y_MAX          = 199
) (
    input  logic             clk,
    input  logic             reset,
    gpu_cmd_parser_if.slave  cmd,
    output logic [8:0]       X1,
    output logic [8:0]       X2,
    output logic [7:0]       Y1,
    output logic [7:0]       Y2,
    output logic             fill_value,
    output logic             start_fill,
    output logic             busy,
    output logic             error,
    input  logic             clear_error
);

    typedef enum logic [2:0] {IDLE, RECV, CHECK, ISSUE, WAIT} state_t;

    localparam int             TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]  TLAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]     XMAXC  = 9'(X_MAX);
    localparam logic [7:0]     YMAXC  = 8'(Y_MAX);

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic [8:0]     x1_q, x1_d, x2_q, x2_d;
    logic [7:0]     y1_q, y1_d, y2_q, y2_d;
    logic           fv_q, fv_d;
    logic           err_q, err_d;
    logic [8:0]     col_q, col_d;
    logic [7:0]     row_q, row_d;
    logic [1:0]     extra_q, extra_d;
    logic           ready;
    logic           accept;
    logic           err_set;

    assign ready  = (state_q == IDLE) || (state_q == RECV);
    assign accept = cmd.in_valid && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            idle_q  <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            extra_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            col_q   <= col_d;
            row_q   <= row_d;
            extra_q <= extra_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        fv_d    = fv_q;
        col_d   = col_q;
        row_d   = row_q;
        extra_d = extra_q;
        err_set = 1'b0;

        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (accept) begin
                    if (cmd.in_data[7:1] == 7'h28) begin
                        fv_d    = cmd.in_data[0];
                        idx_d   = 3'd1;
                        state_d = RECV;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            RECV: begin
                // An accepted byte always beats the timeout, even on the expiring cycle
                if (accept) begin
                    idle_d = '0;
                    case (idx_q)
                        3'd1:    x1_d[8]   = cmd.in_data[0];
                        3'd2:    x1_d[7:0] = cmd.in_data;
                        3'd3:    y1_d      = cmd.in_data;
                        3'd4:    x2_d[8]   = cmd.in_data[0];
                        3'd5:    x2_d[7:0] = cmd.in_data;
                        default: y2_d      = cmd.in_data;
                    endcase
                    if (idx_q == 3'd6) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (idle_q == TLAST) begin
                    idle_d  = '0;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            CHECK: begin
                if ((x1_q <= x2_q) && (y1_q <= y2_q) && (x2_q <= XMAXC) && (y2_q <= YMAXC)) begin
                    state_d = ISSUE;
                end else begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                col_d   = x2_q - x1_q;
                row_d   = y2_q - y1_q;
                extra_d = 2'd2;
                state_d = WAIT;
            end
            WAIT: begin
                // W*H-1 column/row steps, 2 extra steps, then one terminal cycle
                if (col_q != 9'd0) begin
                    col_d = col_q - 9'd1;
                end else if (row_q != 8'd0) begin
                    row_d = row_q - 8'd1;
                    col_d = x2_q - x1_q;
                end else if (extra_q != 2'd0) begin
                    extra_d = extra_q - 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_set || (err_q && !clear_error);
    end

    assign cmd.in_ready = ready;
    assign start_fill   = (state_q == ISSUE);
    assign busy         = (state_q == CHECK) || (state_q == ISSUE) || (state_q == WAIT);
    assign error        = err_q;
    assign X1           = x1_q;
    assign X2           = x2_q;
    assign Y1           = y1_q;
    assign Y2           = y2_q;
    assign fill_value   = fv_q;

endmodule

// File: doc/gpu_cmd_parser.md
GPU_CMD_PARSER -- requirements
Module: gpu_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle cycles allowed between bytes of one packet.
REQ-002 SHALL have parameter X_MAX, default 319, meaning the largest legal X coordinate.
REQ-003 SHALL have parameter Y_MAX, default 199, meaning the largest legal Y coordinate.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 SHALL have port in_data, input, 8 bits: the command byte stream.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the parser can accept a byte; a byte transfers when in_valid and in_ready are both 1.
REQ-009 SHALL have ports X1 and X2, output, 9 bits each: the rectangle X bounds.
REQ-010 SHALL have ports Y1 and Y2, output, 8 bits each: the rectangle Y bounds.
REQ-011 SHALL have port fill_value, output, 1 bit: the pixel value to write.
REQ-012 SHALL have port start_fill, output, 1 bit: a one-cycle fill request to the fill engine.
REQ-013 SHALL have port busy, output, 1 bit: high in states CHECK, ISSUE and WAIT.
REQ-014 SHALL have port error, output, 1 bit: sticky error flag.
REQ-015 SHALL have port clear_error, input, 1 bit: clears the error flag.

Function
REQ-016 SHALL implement packet format byte0 = {7'h28, fv}, byte1 = X1[8] in bit0, byte2 = X1[7:0], byte3 = Y1, byte4 = X2[8] in bit0, byte5 = X2[7:0], byte6 = Y2.
REQ-017 SHALL ignore bits [7:1] of bytes 1 and 4.
REQ-018 SHALL implement the states IDLE, RECV, CHECK, ISSUE and WAIT.
REQ-019 SHALL drive in_ready = 1 in IDLE and RECV only.
REQ-020 In IDLE, on an accepted byte with bits [7:1] = 7'h28, SHALL latch fv, set the byte index to 1 and go to RECV.
REQ-021 In IDLE, on any other accepted byte, SHALL set error and remain in IDLE.
REQ-022 In RECV, SHALL latch each accepted byte into the field given by the byte index and clear the idle counter on every accepted byte.
REQ-023 In RECV, SHALL go to CHECK on the cycle after byte6 is accepted.
REQ-024 In RECV, when the idle counter reaches TIMEOUT_CYCLES with no byte accepted, SHALL discard the partial packet, set error and go to IDLE.
REQ-025 In RECV, a byte accepted on the same cycle the counter would expire SHALL be taken and the timeout SHALL NOT fire.
REQ-026 CHECK SHALL last 1 cycle and pass only if X1<=X2, Y1<=Y2, X2<=X_MAX and Y2<=Y_MAX; on pass go to ISSUE, else set error and go to IDLE with no start_fill.
REQ-027 ISSUE SHALL last 1 cycle with start_fill = 1 and SHALL load the wait counters with col = X2-X1, row = Y2-Y1 and extra = 2.
REQ-028 WAIT SHALL last exactly W*H+2 cycles, where W = X2-X1+1 and H = Y2-Y1+1, using nested column/row counters with no multiplier, then go to IDLE.
REQ-029 WAIT duration SHALL cover the fill engine's initiate cycle, its W*H write cycles and its return to ready.
REQ-030 SHALL compute counter widths with no truncation; the counters SHALL be 9 and 8 bits.
REQ-031 SHALL hold X1, Y1, X2, Y2 and fill_value stable from ISSUE through the end of WAIT.
REQ-032 SHALL keep start_fill at 0 in every state except ISSUE.
REQ-033 SHALL clear error on clear_error; if clear_error and a new error occur on the same cycle, error SHALL be 1 (set wins).
REQ-034 SHALL ignore in_data whenever in_ready = 0.

Reset
REQ-035 On reset assertion, state SHALL go to IDLE immediately, independent of clk.
REQ-036 Reset SHALL drive in_ready = 1 and start_fill, busy, error, X1, Y1, X2, Y2 and fill_value = 0.
REQ-037 Reset SHALL abort any packet or wait in progress and clear all counters.

Verification
REQ-038 Bytes 0x51,0x00,0x0A,0x05,0x00,0x0D,0x06 -> X1=10, Y1=5, X2=13, Y2=6, fill_value=1; start_fill high 1 cycle at T; busy high; in_ready=1 again at T+11.
REQ-039 Header 0x33 -> error=1, no start_fill, in_ready stays 1; then clear_error pulse -> error=0.
REQ-040 Packet with X1=20, X2=10 -> error=1, no start_fill, back in IDLE 1 cycle after CHECK; same for Y2=200.
REQ-041 TIMEOUT_CYCLES=16, send 3 bytes then stop -> after 16 idle cycles error=1 and IDLE; a fresh valid packet then issues normally.
REQ-042 Full screen 0..319 x 0..199 -> WAIT lasts 64002 cycles; bytes offered during WAIT are not accepted.
REQ-043 Reset asserted mid-WAIT and mid-RECV -> in_ready=1, busy=0, start_fill=0 immediately; next packet parsed from byte0.
